// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// dds_pkg : shared opcodes, FSM encoding and strobe-path constants
// Rev 1.0
// ============================================================================
package dds_pkg;

   localparam logic [1:0] OP_TUNE   = 2'b00;
   localparam logic [1:0] OP_SEL    = 2'b01;
   localparam logic [1:0] OP_MODE   = 2'b10;
   localparam logic [1:0] OP_COMMIT = 2'b11;

   typedef enum logic [1:0] {
      CMD  = 2'b00,
      HI   = 2'b01,
      LO   = 2'b10,
      WAIT = 2'b11
   } state_e;

   localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/strb_sync.sv
`default_nettype none
// ============================================================================
// strb_sync : pin-strobe synchronizer with rising-edge detector -> pulse_o
// Rev 1.0
// ============================================================================
module strb_sync
   import dds_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strb_i,
   output logic pulse_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] fill_q;
   logic              last_q;
   logic              armed_q;

   // Edges are only honoured once the synchronized strobe has been seen low
   // after reset, so a strobe held high through reset release is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         fill_q  <= '0;
         last_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], strb_i};
         fill_q  <= {fill_q[STAGES-2:0], 1'b1};
         last_q  <= sync_q[STAGES-1];
         armed_q <= armed_q | (fill_q[STAGES-1] & ~sync_q[STAGES-1]);
      end
   end

   assign pulse_o = armed_q & sync_q[STAGES-1] & ~last_q;

endmodule
`default_nettype wire

// File: rtl/dds_voice_sequencer.sv
`default_nettype none
// ============================================================================
// dds_voice_sequencer : byte-serial shadow-register loader for two DDS voices
// Rev 1.0
// ============================================================================
module dds_voice_sequencer
   import dds_pkg::*;
#(
   parameter int TUNE_W = 16,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_strb,
   input  logic [7:0]        wr_data,
   input  logic              tick,
   output logic [TUNE_W-1:0] tuning0,
   output logic [TUNE_W-1:0] tuning1,
   output logic [SEL_W-1:0]  sel0,
   output logic [SEL_W-1:0]  sel1,
   output logic              psel,
   output logic              osel,
   output logic              busy,
   output logic              err
);

   logic byte_v;

   strb_sync #(
      .STAGES (SYNC_STAGES)
   ) u_strb_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .strb_i  (wr_strb),
      .pulse_o (byte_v)
   );

   state_e            state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic              voice_q, voice_d;
   logic [TUNE_W-1:0] sh_tune0_q, sh_tune0_d;
   logic [TUNE_W-1:0] sh_tune1_q, sh_tune1_d;
   logic [SEL_W-1:0]  sh_sel0_q, sh_sel0_d;
   logic [SEL_W-1:0]  sh_sel1_q, sh_sel1_d;
   logic              sh_psel_q, sh_psel_d;
   logic              sh_osel_q, sh_osel_d;
   logic              err_q, err_d;
   logic              commit;

   logic [TUNE_W-1:0] act_tune0_q, act_tune1_q;
   logic [SEL_W-1:0]  act_sel0_q, act_sel1_q;
   logic              act_psel_q, act_osel_q;

   logic [1:0]        opcode;
   logic [15:0]       full_word;
   logic [TUNE_W-1:0] tune_word;

   assign opcode    = wr_data[7:6];
   assign full_word = {hi_q, wr_data};
   assign tune_word = full_word[TUNE_W-1:0];

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      voice_d    = voice_q;
      sh_tune0_d = sh_tune0_q;
      sh_tune1_d = sh_tune1_q;
      sh_sel0_d  = sh_sel0_q;
      sh_sel1_d  = sh_sel1_q;
      sh_psel_d  = sh_psel_q;
      sh_osel_d  = sh_osel_q;
      err_d      = err_q;
      commit     = 1'b0;

      case (state_q)
         CMD: begin
            if (byte_v) begin
               case (opcode)
                  OP_TUNE: begin
                     voice_d = wr_data[5];
                     state_d = HI;
                  end
                  OP_SEL: begin
                     if (wr_data[5]) sh_sel1_d = wr_data[SEL_W-1:0];
                     else            sh_sel0_d = wr_data[SEL_W-1:0];
                  end
                  OP_MODE: begin
                     sh_psel_d = wr_data[1];
                     sh_osel_d = wr_data[0];
                  end
                  default: state_d = WAIT;
               endcase
            end
         end
         HI: begin
            if (byte_v) begin
               hi_d    = wr_data;
               state_d = LO;
            end
         end
         LO: begin
            if (byte_v) begin
               if (voice_q) sh_tune1_d = tune_word;
               else         sh_tune0_d = tune_word;
               state_d = CMD;
            end
         end
         WAIT: begin
            // A byte arriving with the tick still flags the error.
            if (tick) begin
               commit  = 1'b1;
               err_d   = 1'b0;
               state_d = CMD;
            end
            if (byte_v) err_d = 1'b1;
         end
         default: state_d = CMD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= CMD;
         hi_q       <= '0;
         voice_q    <= 1'b0;
         sh_tune0_q <= '0;
         sh_tune1_q <= '0;
         sh_sel0_q  <= '0;
         sh_sel1_q  <= '0;
         sh_psel_q  <= 1'b0;
         sh_osel_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         voice_q    <= voice_d;
         sh_tune0_q <= sh_tune0_d;
         sh_tune1_q <= sh_tune1_d;
         sh_sel0_q  <= sh_sel0_d;
         sh_sel1_q  <= sh_sel1_d;
         sh_psel_q  <= sh_psel_d;
         sh_osel_q  <= sh_osel_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_tune0_q <= '0;
         act_tune1_q <= '0;
         act_sel0_q  <= '0;
         act_sel1_q  <= '0;
         act_psel_q  <= 1'b0;
         act_osel_q  <= 1'b0;
      end else if (commit) begin
         act_tune0_q <= sh_tune0_q;
         act_tune1_q <= sh_tune1_q;
         act_sel0_q  <= sh_sel0_q;
         act_sel1_q  <= sh_sel1_q;
         act_psel_q  <= sh_psel_q;
         act_osel_q  <= sh_osel_q;
      end
   end

   assign tuning0 = act_tune0_q;
   assign tuning1 = act_tune1_q;
   assign sel0    = act_sel0_q;
   assign sel1    = act_sel1_q;
   assign psel    = act_psel_q;
   assign osel    = act_osel_q;
   assign busy    = (state_q != CMD);
   assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dds_voice_sequencer : directed + random bytes against a protocol model
// Rev 1.0
// ============================================================================
module tb_dds_voice_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_strb;
   logic [7:0]  wr_data;
   logic        tick;
   logic [15:0] tuning0, tuning1;
   logic [2:0]  sel0, sel1;
   logic        psel, osel, busy, err;

   dds_voice_sequencer #(
      .TUNE_W (16),
      .SEL_W  (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_strb (wr_strb),
      .wr_data (wr_data),
      .tick    (tick),
      .tuning0 (tuning0),
      .tuning1 (tuning1),
      .sel0    (sel0),
      .sel1    (sel1),
      .psel    (psel),
      .osel    (osel),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Protocol-level model: pending tuning bytes, a waiting-for-tick flag,
   // shadow and active copies of every voice setting.
   logic [15:0] m_sh_tune [2];
   logic [2:0]  m_sh_sel  [2];
   logic        m_sh_psel, m_sh_osel;
   logic [15:0] m_tune [2];
   logic [2:0]  m_sel  [2];
   logic        m_psel, m_osel, m_err;
   int          m_pend;
   int          m_voice;
   logic [7:0]  m_hi;
   bit          m_wait;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_sh_tune[i] = '0; m_sh_sel[i] = '0;
         m_tune[i]    = '0; m_sel[i]    = '0;
      end
      m_sh_psel = 0; m_sh_osel = 0; m_psel = 0; m_osel = 0; m_err = 0;
      m_pend = 0; m_voice = 0; m_hi = '0; m_wait = 0;
   endfunction

   function automatic void model_event(bit has_byte, logic [7:0] b, bit has_tick);
      if (m_wait) begin
         if (has_byte) m_err = 1;
         if (has_tick) begin
            for (int i = 0; i < 2; i++) begin
               m_tune[i] = m_sh_tune[i];
               m_sel[i]  = m_sh_sel[i];
            end
            m_psel = m_sh_psel;
            m_osel = m_sh_osel;
            if (!has_byte) m_err = 0;
            m_wait = 0;
         end
      end else if (has_byte) begin
         if (m_pend == 2) begin
            m_hi   = b;
            m_pend = 1;
         end else if (m_pend == 1) begin
            m_sh_tune[m_voice] = m_hi * 16'd256 + b;
            m_pend = 0;
         end else begin
            case (b / 64)
               0: begin m_voice = b[5] ? 1 : 0; m_pend = 2; end
               1: m_sh_sel[b[5] ? 1 : 0] = b % 8;
               2: begin m_sh_psel = b[1]; m_sh_osel = b[0]; end
               default: m_wait = 1;
            endcase
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      chk({step, ".tuning0"}, 32'(tuning0), 32'(m_tune[0]));
      chk({step, ".tuning1"}, 32'(tuning1), 32'(m_tune[1]));
      chk({step, ".sel0"},    32'(sel0),    32'(m_sel[0]));
      chk({step, ".sel1"},    32'(sel1),    32'(m_sel[1]));
      chk({step, ".psel"},    32'(psel),    32'(m_psel));
      chk({step, ".osel"},    32'(osel),    32'(m_osel));
      chk({step, ".busy"},    32'(busy),    32'(m_wait || m_pend != 0));
      chk({step, ".err"},     32'(err),     32'(m_err));
   endtask

   // Strobe rises at a negedge; the byte is consumed on the third rising edge.
   task automatic send_byte(input logic [7:0] b, input bit tick_same);
      @(negedge clk);
      wr_data = b;
      wr_strb = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      if (tick_same) tick = 1'b1;
      @(posedge clk);
      model_event(1, b, tick_same);
      @(negedge clk);
      tick    = 1'b0;
      wr_strb = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      model_event(0, 8'h00, 1);
      @(negedge clk);
      tick = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_strb = 1'b1;
      wr_data = 8'h00;
      tick    = 1'b0;
      model_reset();

      // Strobe high through reset release must not produce a byte.
      repeat (3) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_all("strb_held");
      wr_strb = 1'b0;
      repeat (4) @(negedge clk);
      check_all("strb_drop");

      send_byte(8'h00, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'hC0, 0);
      check_all("tune_pre_tick");
      do_tick();
      check_all("tune_commit");

      send_byte(8'h20, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'h45, 0);
      send_byte(8'h63, 0);
      send_byte(8'h82, 0);
      send_byte(8'hC0, 0);
      check_all("atomic_pre_tick");
      do_tick();
      check_all("atomic_commit");

      send_byte(8'hC0, 0);
      send_byte(8'h41, 0);
      check_all("wait_reject");
      do_tick();
      check_all("wait_reject_tick");
      send_byte(8'hC0, 0);
      do_tick();
      check_all("clean_commit");

      send_byte(8'hC0, 0);
      send_byte(8'h52, 1);
      check_all("tick_and_byte");

      send_byte(8'h46, 0);
      send_byte(8'hC0, 1);
      check_all("same_cycle_tick");
      repeat (2) @(negedge clk);
      check_all("same_cycle_idle");
      do_tick();
      check_all("same_cycle_next");

      do_tick();
      check_all("idle_tick");

      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'hC0, 0);
      do_tick();
      check_all("post_reset");

      for (int i = 0; i < 60; i++) begin
         send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) do_tick();
         check_all("random");
      end
      do_tick();
      check_all("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
